ram_responder: RTL and testbench
================================

# ram_responder

Synchronous, single-port word RAM with a configurable access latency. It sits on the RAM side of the memory controller: it accepts the arbitrated `ramREN`/`ramWEN`/`ramaddr`/`ramstore` request and returns `ramload` plus the `ramstate` status (FREE/BUSY/ACCESS/ERROR) that the controller turns into `iwait`/`dwait`. It serves as the bench and synthesis stand-in for the real RAM, so its latency and error behaviour must be exact.

## Interface
- `LAT`, 2: BUSY cycles before ACCESS. Legal range 0..15.
- `MEM_WORDS`, 1024: depth in 32-bit words. Valid byte addresses are 0 .. 4*MEM_WORDS-4.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous and active-high.
- `ramREN`  in  1  read request; level, held by the controller until ACCESS.
- `ramWEN`  in  1  write request; level, held until ACCESS.
- `ramaddr`  in  32  byte address; word index is `ramaddr[31:2]`.
- `ramstore`  in  32  write data.
- `ramload`  out  32  read data; registered.
- `ramstate`  out  2  FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11 (cpu_types_pkg encoding).

## Operation
- Internal state: FSM {IDLE, WAIT, DONE, ERR}, latency counter `cnt` of 4 bits, latched op (rd/wr), latched address, latched data.
- `ramstate` decodes directly from the FSM: IDLE→FREE, WAIT→BUSY, DONE→ACCESS, ERR→ERROR.
- A request is **legal** when exactly one of `ramREN`/`ramWEN` is high, `ramaddr[1:0]==0`, and the word index is < `MEM_WORDS`.
- **IDLE**
  - No request: stay in IDLE.
  - Illegal request, including REN and WEN both high: go to ERR.
  - Legal request with LAT>0: latch op, address and data, load `cnt` with LAT, go to WAIT.
  - Legal request with LAT==0: commit immediately (see commit rules) and go to DONE.
- **WAIT**
  - Each cycle, compare the live request (REN, WEN, address, and store data for writes) against the latched request.
  - Request dropped (REN=WEN=0): go to IDLE. No write occurs and `ramload` is unchanged.
  - Request changed but still legal: re-latch, reload `cnt` with LAT, stay in WAIT. This restarts the latency.
  - Request changed and illegal: go to ERR.
  - Unchanged with `cnt>1`: decrement `cnt`.
  - Unchanged with `cnt==1`: commit and go to DONE.
- **Commit**
  - Read: `ramload <= mem[idx]`.
  - Write: `mem[idx] <= ramstore`, and `ramload` is unchanged.
- **DONE**: lasts exactly one cycle, then IDLE. The request is not sampled in DONE.
- **ERR**: lasts exactly one cycle, then IDLE. No memory access; `ramload` is forced to 0.
- **Reset** (RST high at an edge, from any state, including mid-WAIT): FSM→IDLE, `cnt`=0, `ramload`=0, all memory words cleared to 0. A pending write is discarded.

## Timing
- Reset values: `ramstate`=FREE, `ramload`=32'h0.
- Request first sampled high in IDLE at edge E0:
  - BUSY for cycles E0+1 .. E0+LAT.
  - ACCESS in cycle E0+LAT+1, with `ramload` valid throughout that cycle for reads.
  - Total occupancy is LAT+2 cycles, counting the FREE cycle in which the request appears.
- A write is visible to a read issued in the cycle after ACCESS.
- Back-to-back requests:
  - Earliest restart is the cycle after ACCESS (FREE), because DONE does not sample the request.
  - Steady-state throughput is one access per LAT+2 cycles.
- `ramload` holds its last read value through FREE, BUSY and write accesses. It changes only on a read commit, on entry to ERR, or on reset.
- Only the legality check and next-state logic are combinational on the inputs; both outputs are registered.

## Test plan
- **Reset:** assert RST for 2 cycles, including mid-WAIT of a write to 0x10. Required: `ramstate`=FREE, `ramload`=0, and a later read of 0x10 returns 0.
- **Write/read latency (LAT=2):**
  - Write 0xDEADBEEF to 0x40: FREE, BUSY, BUSY, ACCESS, then FREE.
  - Read 0x40: ACCESS appears exactly 3 cycles after the request, with `ramload`=0xDEADBEEF.
- **Abort and restart:**
  - Read 0x40, drop REN after 1 BUSY cycle: return to FREE, `ramload` unchanged.
  - Read 0x40, change `ramaddr` to 0x44 during BUSY: BUSY count restarts at 2, and ACCESS returns mem[0x44].
- **Errors:**
  - REN=WEN=1: one ERROR cycle, then FREE.
  - Address 0x1002 (misaligned): ERROR, `ramload`=0.
  - Address 4*MEM_WORDS: ERROR.
  - In all three cases, memory is unchanged.
- **LAT=0 back-to-back:** hold REN on 0x8 continuously. Required pattern FREE, ACCESS, FREE, ACCESS…, with `ramload` valid in every ACCESS cycle.
- **Random traffic:** 1000 legal and illegal requests checked against a scoreboard model of memory, latency and `ramstate` sequence.

Source files
------------

// File: rtl/ram_responder_if.sv
// Request/response bundle between the memory controller and the RAM.
//   ramREN   : read request (level, held until ACCESS)
//   ramWEN   : write request (level, held until ACCESS)
//   ramaddr  : byte address, word index is ramaddr[31:2]
//   ramstore : write data
//   ramload  : read data returned by the RAM
//   ramstate : FREE=00, BUSY=01, ACCESS=10, ERROR=11
// master = controller side, slave = RAM side.
interface ram_responder_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// Single-port word RAM with a fixed access latency, used as the RAM behind the
// memory controller. Accepts a held REN/WEN request, reports BUSY for LAT
// cycles, then ACCESS for one cycle; illegal requests get one ERROR cycle.
//   CLK    : clock, all state changes on the rising edge
//   RST    : synchronous active-high reset, clears FSM, ramload and memory
//   io_ram : slave side of ram_responder_if (request in, ramload/ramstate out)
// Parameters:
//   LAT       : BUSY cycles before ACCESS (0..15)
//   MEM_WORDS : depth in 32-bit words
module ram_responder #(
  parameter int unsigned LAT       = 2,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic            CLK,
  input  logic            RST,
  ram_responder_if.slave  io_ram
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone, StErr} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_d;
  logic            r_ren;
  logic            r_wen;
  logic [31:0]     r_addr;
  logic [31:0]     r_data;
  logic [31:0]     r_load;
  logic [31:0]     r_mem [MEM_WORDS];

  logic            w_legal;
  logic            w_dropped;
  logic            w_changed;
  logic            w_latch;
  logic            w_commit;
  logic [IdxW-1:0] w_idx;

  assign w_legal   = (io_ram.ramREN ^ io_ram.ramWEN) &&
                     (io_ram.ramaddr[1:0] == 2'b00) &&
                     ({2'b00, io_ram.ramaddr[31:2]} < MEM_WORDS);
  assign w_dropped = !io_ram.ramREN && !io_ram.ramWEN;
  // Store data only matters for writes; a read with changing ramstore is unchanged.
  assign w_changed = (io_ram.ramREN != r_ren) || (io_ram.ramWEN != r_wen) ||
                     (io_ram.ramaddr != r_addr) ||
                     (io_ram.ramWEN && (io_ram.ramstore != r_data));
  // Commit happens only when the live request is legal (and equals the latched
  // one in WAIT), so the live inputs can address the memory directly.
  assign w_idx     = io_ram.ramaddr[IdxW+1:2];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_latch   = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_dropped) begin
          if (!w_legal) begin
            w_state_d = StErr;
          end else if (LAT == 0) begin
            w_commit  = 1'b1;
            w_state_d = StDone;
          end else begin
            w_latch   = 1'b1;
            w_cnt_d   = 4'(LAT);
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (w_dropped) begin
          w_state_d = StIdle;
        end else if (w_changed) begin
          if (w_legal) begin
            // Restart the latency on the new request.
            w_latch = 1'b1;
            w_cnt_d = 4'(LAT);
          end else begin
            w_state_d = StErr;
          end
        end else if (r_cnt > 4'd1) begin
          w_cnt_d = r_cnt - 4'd1;
        end else begin
          w_commit  = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_latch) begin
        r_ren  <= io_ram.ramREN;
        r_wen  <= io_ram.ramWEN;
        r_addr <= io_ram.ramaddr;
        r_data <= io_ram.ramstore;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        r_mem[i] <= 32'h0;
      end
      r_load <= 32'h0;
    end else begin
      if (w_commit && io_ram.ramWEN) begin
        r_mem[w_idx] <= io_ram.ramstore;
      end
      if (w_commit && io_ram.ramREN) begin
        r_load <= r_mem[w_idx];
      end else if (w_state_d == StErr) begin
        r_load <= 32'h0;
      end
    end
  end

  always_comb begin
    io_ram.ramstate = 2'b00;
    unique case (r_state)
      StIdle:  io_ram.ramstate = 2'b00;
      StWait:  io_ram.ramstate = 2'b01;
      StDone:  io_ram.ramstate = 2'b10;
      StErr:   io_ram.ramstate = 2'b11;
      default: io_ram.ramstate = 2'b00;
    endcase
  end

  assign io_ram.ramload = r_load;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  localparam int unsigned Lat      = 2;
  localparam int unsigned MemWords = 1024;

  localparam logic [1:0] Free   = 2'b00;
  localparam logic [1:0] Busy   = 2'b01;
  localparam logic [1:0] Access = 2'b10;
  localparam logic [1:0] Error  = 2'b11;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_responder_if if0 ();
  ram_responder_if if1 ();

  ram_responder #(.LAT(Lat), .MEM_WORDS(MemWords)) dut0 (
    .CLK    (clk),
    .RST    (rst),
    .io_ram (if0)
  );

  ram_responder #(.LAT(0), .MEM_WORDS(MemWords)) dut1 (
    .CLK    (clk),
    .RST    (rst),
    .io_ram (if1)
  );

  // Reference model: plain word array plus the last value ramload should show.
  logic [31:0] ref_mem [MemWords];
  logic [31:0] ref_load;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input bit ren, input bit wen, input logic [31:0] addr);
    logic [29:0] widx;
    widx = addr[31:2];
    return (ren ^ wen) && (addr[1:0] == 2'b00) && (widx < 30'(MemWords));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = 32'h0;
    ref_load = 32'h0;
  endtask

  // Issue one request on the LAT=2 port, hold it until ACCESS/ERROR, then release.
  task automatic drive_request(input string name, input bit ren, input bit wen,
                               input logic [31:0] addr, input logic [31:0] data);
    bit          legal;
    logic [29:0] widx;
    legal = is_legal(ren, wen, addr);
    widx  = addr[31:2];
    if0.ramREN   = ren;
    if0.ramWEN   = wen;
    if0.ramaddr  = addr;
    if0.ramstore = data;
    n_checks++;
    if (if0.ramstate !== Free)
      $display("FAIL %s req-cycle state: got %b want %b", name, if0.ramstate, Free);
    else n_pass++;
    if (legal) begin
      for (int i = 0; i < int'(Lat); i++) begin
        tick();
        n_checks++;
        if (if0.ramstate !== Busy)
          $display("FAIL %s busy%0d state: got %b want %b", name, i, if0.ramstate, Busy);
        else n_pass++;
        n_checks++;
        if (if0.ramload !== ref_load)
          $display("FAIL %s busy%0d load: got %h want %h", name, i, if0.ramload, ref_load);
        else n_pass++;
      end
      tick();
      if (ren) ref_load = ref_mem[widx];
      else     ref_mem[widx] = data;
      n_checks++;
      if (if0.ramstate !== Access)
        $display("FAIL %s access state: got %b want %b", name, if0.ramstate, Access);
      else n_pass++;
    end else begin
      tick();
      ref_load = 32'h0;
      n_checks++;
      if (if0.ramstate !== Error)
        $display("FAIL %s error state: got %b want %b", name, if0.ramstate, Error);
      else n_pass++;
    end
    n_checks++;
    if (if0.ramload !== ref_load)
      $display("FAIL %s done load: got %h want %h", name, if0.ramload, ref_load);
    else n_pass++;
    if0.ramREN = 1'b0;
    if0.ramWEN = 1'b0;
    tick();
    n_checks++;
    if (if0.ramstate !== Free || if0.ramload !== ref_load)
      $display("FAIL %s after: got state %b load %h want state %b load %h",
               name, if0.ramstate, if0.ramload, Free, ref_load);
    else n_pass++;
  endtask

  task automatic test_reset();
    if0.ramREN = 1'b0; if0.ramWEN = 1'b0; if0.ramaddr = '0; if0.ramstore = '0;
    if1.ramREN = 1'b0; if1.ramWEN = 1'b0; if1.ramaddr = '0; if1.ramstore = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (if0.ramstate !== Free || if0.ramload !== 32'h0)
      $display("FAIL reset dut0: got state %b load %h want 00 0", if0.ramstate, if0.ramload);
    else n_pass++;
    n_checks++;
    if (if1.ramstate !== Free || if1.ramload !== 32'h0)
      $display("FAIL reset dut1: got state %b load %h want 00 0", if1.ramstate, if1.ramload);
    else n_pass++;
  endtask

  task automatic test_write_read();
    drive_request("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    drive_request("rd40", 1'b1, 1'b0, 32'h40, 32'h0);
    n_checks++;
    if (ref_load !== 32'hDEADBEEF || if0.ramload !== 32'hDEADBEEF)
      $display("FAIL rd40 value: got %h want %h", if0.ramload, 32'hDEADBEEF);
    else n_pass++;
    drive_request("wr44", 1'b0, 1'b1, 32'h44, 32'h12345678);
  endtask

  task automatic test_abort();
    // Drop REN after one BUSY cycle.
    if0.ramREN = 1'b1; if0.ramWEN = 1'b0; if0.ramaddr = 32'h40;
    tick();
    n_checks++;
    if (if0.ramstate !== Busy)
      $display("FAIL abort busy: got %b want %b", if0.ramstate, Busy);
    else n_pass++;
    if0.ramREN = 1'b0;
    tick();
    n_checks++;
    if (if0.ramstate !== Free || if0.ramload !== ref_load)
      $display("FAIL abort free: got state %b load %h want state %b load %h",
               if0.ramstate, if0.ramload, Free, ref_load);
    else n_pass++;
    // Change address mid-BUSY: latency restarts from the change.
    if0.ramREN = 1'b1; if0.ramaddr = 32'h40;
    tick();
    n_checks++;
    if (if0.ramstate !== Busy)
      $display("FAIL restart busy0: got %b want %b", if0.ramstate, Busy);
    else n_pass++;
    if0.ramaddr = 32'h44;
    for (int i = 0; i < int'(Lat); i++) begin
      tick();
      n_checks++;
      if (if0.ramstate !== Busy)
        $display("FAIL restart busy%0d: got %b want %b", i + 1, if0.ramstate, Busy);
      else n_pass++;
    end
    tick();
    ref_load = ref_mem[17];
    n_checks++;
    if (if0.ramstate !== Access || if0.ramload !== ref_load)
      $display("FAIL restart access: got state %b load %h want state %b load %h",
               if0.ramstate, if0.ramload, Access, ref_load);
    else n_pass++;
    if0.ramREN = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    drive_request("err_both", 1'b1, 1'b1, 32'h40, 32'h11111111);
    drive_request("err_misal", 1'b1, 1'b0, 32'h1002, 32'h0);
    drive_request("err_oob", 1'b0, 1'b1, 32'(4 * MemWords), 32'h22222222);
    drive_request("err_misal_wr", 1'b0, 1'b1, 32'h42, 32'h33333333);
    drive_request("chk_rd40", 1'b1, 1'b0, 32'h40, 32'h0);
    drive_request("chk_rd44", 1'b1, 1'b0, 32'h44, 32'h0);
    drive_request("chk_rd00", 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_lat0_back_to_back();
    logic [31:0] val;
    val = 32'hA5A50008;
    if1.ramWEN = 1'b1; if1.ramaddr = 32'h8; if1.ramstore = val;
    tick();
    n_checks++;
    if (if1.ramstate !== Access)
      $display("FAIL lat0 wr access: got %b want %b", if1.ramstate, Access);
    else n_pass++;
    if1.ramWEN = 1'b0;
    tick();
    if1.ramREN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (if1.ramstate !== Free)
        $display("FAIL lat0 free%0d: got %b want %b", i, if1.ramstate, Free);
      else n_pass++;
      tick();
      n_checks++;
      if (if1.ramstate !== Access || if1.ramload !== val)
        $display("FAIL lat0 access%0d: got state %b load %h want state %b load %h",
                 i, if1.ramstate, if1.ramload, Access, val);
      else n_pass++;
      tick();
    end
    if1.ramREN = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit          ren, wen;
    logic [31:0] addr;
    int          kind;
    for (int n = 0; n < 1000; n++) begin
      kind = int'($urandom_range(0, 99));
      addr = 32'($urandom_range(0, 31)) << 2;
      if (kind < 45) begin
        ren = 1'b1; wen = 1'b0;
      end else if (kind < 80) begin
        ren = 1'b0; wen = 1'b1;
      end else begin
        ren = 1'($urandom_range(0, 1));
        wen = ~ren;
        if (kind < 87) begin
          ren = 1'b1; wen = 1'b1;
        end else if (kind < 94) begin
          addr = addr + 32'($urandom_range(1, 3));
        end else begin
          addr = (32'(MemWords) + 32'($urandom_range(0, 255))) << 2;
        end
      end
      drive_request("rand", ren, wen, addr, $urandom);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive_request("pre_wr10", 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
    if0.ramWEN = 1'b1; if0.ramaddr = 32'h10; if0.ramstore = 32'h0BADF00D;
    tick();
    n_checks++;
    if (if0.ramstate !== Busy)
      $display("FAIL rst_mid busy: got %b want %b", if0.ramstate, Busy);
    else n_pass++;
    rst = 1'b1;
    tick();
    tick();
    if0.ramWEN = 1'b0;
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (if0.ramstate !== Free || if0.ramload !== 32'h0)
      $display("FAIL rst_mid state: got state %b load %h want 00 0", if0.ramstate, if0.ramload);
    else n_pass++;
    drive_request("post_rd10", 1'b1, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (if0.ramload !== 32'h0)
      $display("FAIL post_rd10 value: got %h want 0", if0.ramload);
    else n_pass++;
    drive_request("post_rd40", 1'b1, 1'b0, 32'h40, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_errors();
    test_lat0_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
